// File: rtl/dma_bram_port_if.sv
// DMA-side memory interface of dma_bram_port: single-word read requests with
// in-order fixed-latency return, plus unconditional single-word writes.
interface dma_bram_port_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_r_ready;
    logic [ADDR_WIDTH-1:0] mem_r_addr;
    logic                  mem_r_ack;
    logic                  mem_r_valid;
    logic [DATA_WIDTH-1:0] mem_r_data;
    logic                  mem_w_valid;
    logic [ADDR_WIDTH-1:0] mem_w_addr;
    logic [DATA_WIDTH-1:0] mem_w_data;

    // DMA controller side
    modport master (
        output mem_r_ready, mem_r_addr, mem_w_valid, mem_w_addr, mem_w_data,
        input  mem_r_ack, mem_r_valid, mem_r_data
    );

    // Memory port side
    modport slave (
        input  mem_r_ready, mem_r_addr, mem_w_valid, mem_w_addr, mem_w_data,
        output mem_r_ack, mem_r_valid, mem_r_data
    );
endinterface

// File: rtl/dma_bram_port.sv
// Memory-side port between the DMA controller and a single-port user BRAM.
// Writes win arbitration over reads; reads return in order after BRAM_LAT+2
// cycles, with at most MAX_OUTST reads in flight.
module dma_bram_port #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int BRAM_LAT   = 2,
    parameter int MAX_OUTST  = 4
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_i,
    dma_bram_port_if.slave                     dma,
    output logic                               bram_en,
    output logic [3:0]                         bram_we,
    output logic [ADDR_WIDTH-1:0]              bram_addr,
    output logic [DATA_WIDTH-1:0]              bram_wdata,
    input  logic [DATA_WIDTH-1:0]              bram_rdata,
    output logic [$clog2(MAX_OUTST+1)-1:0]     rd_inflight,
    output logic                               busy
);

    localparam int CNT_W = $clog2(MAX_OUTST+1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    logic                  rd_ack;
    logic [BRAM_LAT:0]     rd_tag_p;
    logic                  rd_vld_p;
    logic [DATA_WIDTH-1:0] rd_data_p;

    // Outstanding-read count: ack and return in the same cycle cancel out.
    function automatic logic [CNT_W-1:0] next_inflight(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        case ({inc, dec})
            2'b10:   return cur + 1'b1;
            2'b01:   return cur - 1'b1;
            default: return cur;
        endcase
    endfunction

    // Arbitration: a write always wins; a read is accepted only with credit left.
    always_comb begin
        rd_ack = 1'b0;
        if (!wb_rst_i && !dma.mem_w_valid && dma.mem_r_ready && (rd_inflight < MAX_CNT))
            rd_ack = 1'b1;
    end

    assign dma.mem_r_ack   = rd_ack;
    assign dma.mem_r_valid = rd_vld_p;
    assign dma.mem_r_data  = rd_data_p;
    assign busy            = (rd_inflight != '0) || bram_en;

    // Issue stage: register the selected access onto the BRAM port.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bram_en    <= 1'b0;
            bram_we    <= 4'h0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else if (dma.mem_w_valid) begin
            bram_en    <= 1'b1;
            bram_we    <= 4'hF;
            bram_addr  <= dma.mem_w_addr;
            bram_wdata <= dma.mem_w_data;
        end else if (rd_ack) begin
            bram_en    <= 1'b1;
            bram_we    <= 4'h0;
            bram_addr  <= dma.mem_r_addr;
        end else begin
            bram_en    <= 1'b0;
            bram_we    <= 4'h0;
        end
    end

    // Return stage: a tag follows each read through the BRAM latency, then the data is captured.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_tag_p  <= '0;
            rd_vld_p  <= 1'b0;
            rd_data_p <= '0;
        end else begin
            rd_tag_p <= {rd_tag_p[BRAM_LAT-1:0], rd_ack};
            rd_vld_p <= rd_tag_p[BRAM_LAT];
            if (rd_tag_p[BRAM_LAT])
                rd_data_p <= bram_rdata;
        end
    end

    // Credit counter for reads accepted and not yet returned.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            rd_inflight <= '0;
        else
            rd_inflight <= next_inflight(rd_inflight, rd_ack, rd_vld_p);
    end

endmodule

// File: tb/tb_dma_bram_port.sv
// Bench for dma_bram_port: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a transaction-level reference model.
module tb_dma_bram_port;

    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int MO  = 4;
    localparam int RD_LATENCY = LAT + 2;

    logic          clk;
    logic          rst;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;
    logic [2:0]    rd_inflight;
    logic          busy;

    dma_bram_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dma ();

    dma_bram_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_LAT(LAT), .MAX_OUTST(MO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .dma         (dma.slave),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .bram_rdata  (bram_rdata),
        .rd_inflight (rd_inflight),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM with LAT cycles of read latency
    logic [DW-1:0] bram_mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe  [0:LAT-1];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we == 4'hF) bram_mem[bram_addr] <= bram_wdata;
            rd_pipe[0] <= bram_mem[bram_addr];
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rdata = rd_pipe[LAT-1];

    // Reference model state
    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t          exp_q [$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_inflight = 0;
    int            prev_kind  = 0;   // 0 idle, 1 write, 2 read
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    int            cyc = 0;
    bit            chk_en = 0;

    int errors = 0;
    int checks = 0;

    logic          last_ack, last_valid, last_en;
    logic [DW-1:0] last_data;
    logic [AW-1:0] last_baddr;
    logic [2:0]    last_inflight;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, check, update model, advance.
    task automatic cycle();
        bit exp_ack, exp_v;
        @(negedge clk);
        exp_ack = !rst && !dma.mem_w_valid && dma.mem_r_ready && (m_inflight < MO);
        exp_v   = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (chk_en) begin
            chk("ack", 32'(dma.mem_r_ack), 32'(exp_ack));
            chk("inflight", 32'(rd_inflight), 32'(m_inflight));
            chk("busy", 32'(busy), 32'((m_inflight != 0) || (prev_kind != 0)));
            chk("bram_en", 32'(bram_en), 32'(prev_kind != 0));
            if (prev_kind == 1) begin
                chk("bram_we_wr", 32'(bram_we), 32'hF);
                chk("bram_addr_wr", 32'(bram_addr), 32'(prev_addr));
                chk("bram_wdata", bram_wdata, prev_data);
            end else if (prev_kind == 2) begin
                chk("bram_we_rd", 32'(bram_we), 32'h0);
                chk("bram_addr_rd", 32'(bram_addr), 32'(prev_addr));
            end else begin
                chk("bram_we_idle", 32'(bram_we), 32'h0);
            end
            chk("r_valid", 32'(dma.mem_r_valid), 32'(exp_v));
            if (exp_v) chk("r_data", dma.mem_r_data, exp_q[0].data);
        end
        last_ack      = dma.mem_r_ack;
        last_valid    = dma.mem_r_valid;
        last_data     = dma.mem_r_data;
        last_en       = bram_en;
        last_baddr    = bram_addr;
        last_inflight = rd_inflight;

        if (exp_v) void'(exp_q.pop_front());
        if (exp_ack) exp_q.push_back('{data: ref_mem[dma.mem_r_addr], due: cyc + RD_LATENCY});
        m_inflight = m_inflight + int'(exp_ack) - int'(exp_v);
        if (rst) begin
            prev_kind = 0;
        end else if (dma.mem_w_valid) begin
            prev_kind = 1;
            prev_addr = dma.mem_w_addr;
            prev_data = dma.mem_w_data;
            ref_mem[dma.mem_w_addr] = dma.mem_w_data;
        end else if (exp_ack) begin
            prev_kind = 2;
            prev_addr = dma.mem_r_addr;
        end else begin
            prev_kind = 0;
        end
        if (rst) begin
            exp_q.delete();
            m_inflight = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma.mem_w_valid = 1'b1;
        dma.mem_w_addr  = a;
        dma.mem_w_data  = d;
        cycle();
        dma.mem_w_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int lat, n_acked, n_ret, peak, nv;

        rst             = 1'b1;
        dma.mem_r_ready = 1'b1;
        dma.mem_r_addr  = '0;
        dma.mem_w_valid = 1'b0;
        dma.mem_w_addr  = '0;
        dma.mem_w_data  = '0;

        // Reset held for two cycles with a read request pending
        cycle();
        chk_en = 1;
        cycle();
        chk("t1_ack", 32'(last_ack), 32'h0);
        chk("t1_bram_en", 32'(last_en), 32'h0);
        chk("t1_valid", 32'(last_valid), 32'h0);
        chk("t1_inflight", 32'(last_inflight), 32'h0);
        rst = 1'b0;
        dma.mem_r_ready = 1'b0;
        idle(2);

        // Single read of a preloaded word
        wr(13'h10, 32'hDEADBEEF);
        dma.mem_r_ready = 1'b1;
        dma.mem_r_addr  = 13'h10;
        cycle();
        chk("t2_ack", 32'(last_ack), 32'h1);
        dma.mem_r_ready = 1'b0;
        cycle();
        chk("t2_bram_en", 32'(last_en), 32'h1);
        chk("t2_bram_addr", 32'(last_baddr), 32'h10);
        lat = 1;
        while (!last_valid && lat < 12) begin
            cycle();
            lat++;
        end
        chk("t2_latency", 32'(lat), 32'(RD_LATENCY));
        chk("t2_data", last_data, 32'hDEADBEEF);
        idle(3);

        // Burst of eight reads throttled by the outstanding limit
        for (int i = 0; i < 8; i++) wr(AW'(i), 32'(i * 3));
        dma.mem_r_ready = 1'b1;
        dma.mem_r_addr  = '0;
        n_acked = 0;
        n_ret   = 0;
        peak    = 0;
        for (int k = 0; k < 60 && n_ret < 8; k++) begin
            cycle();
            if (int'(last_inflight) > peak) peak = int'(last_inflight);
            if (last_ack) begin
                n_acked++;
                dma.mem_r_addr = AW'(n_acked);
                if (n_acked == 8) dma.mem_r_ready = 1'b0;
            end
            if (last_valid) begin
                chk("t3_order", last_data, 32'(n_ret * 3));
                n_ret++;
            end
        end
        dma.mem_r_ready = 1'b0;
        chk("t3_returns", 32'(n_ret), 32'd8);
        chk("t3_peak", 32'(peak), 32'(MO));
        idle(3);

        // Write and read collide on the same address; read is deferred and sees the write
        dma.mem_w_valid = 1'b1;
        dma.mem_w_addr  = 13'd5;
        dma.mem_w_data  = 32'hA5A5;
        dma.mem_r_ready = 1'b1;
        dma.mem_r_addr  = 13'd5;
        cycle();
        chk("t4_ack_deferred", 32'(last_ack), 32'h0);
        dma.mem_w_valid = 1'b0;
        cycle();
        chk("t4_ack_next", 32'(last_ack), 32'h1);
        dma.mem_r_ready = 1'b0;
        lat = 0;
        last_valid = 1'b0;
        while (!last_valid && lat < 12) begin
            cycle();
            lat++;
        end
        chk("t4_seen", 32'(last_valid), 32'h1);
        chk("t4_data", last_data, 32'hA5A5);
        idle(3);

        // Ack and return in the same cycle at two outstanding reads
        dma.mem_r_ready = 1'b1;
        dma.mem_r_addr  = 13'd1;
        cycle();
        dma.mem_r_addr  = 13'd2;
        cycle();
        dma.mem_r_ready = 1'b0;
        idle(2);
        dma.mem_r_ready = 1'b1;
        dma.mem_r_addr  = 13'd3;
        cycle();
        chk("t5_ack", 32'(last_ack), 32'h1);
        chk("t5_valid", 32'(last_valid), 32'h1);
        chk("t5_inflight_before", 32'(last_inflight), 32'd2);
        dma.mem_r_ready = 1'b0;
        cycle();
        chk("t5_inflight_after", 32'(last_inflight), 32'd2);
        idle(6);

        // Reset while three reads are in flight
        dma.mem_r_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dma.mem_r_addr = AW'(i);
            cycle();
        end
        rst = 1'b1;
        cycle();
        chk("t6_ack_in_reset", 32'(last_ack), 32'h0);
        cycle();
        rst = 1'b0;
        dma.mem_r_ready = 1'b0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_valid) nv++;
        end
        chk("t6_no_valid", 32'(nv), 32'd0);
        chk("t6_inflight", 32'(last_inflight), 32'd0);

        // Randomized traffic over a small address window to provoke RAW hazards
        for (int i = 0; i < 64; i++) wr(AW'(i), $urandom);
        for (int i = 0; i < 300; i++) begin
            dma.mem_w_valid = ($urandom_range(0, 3) == 0);
            dma.mem_w_addr  = AW'($urandom_range(0, 63));
            dma.mem_w_data  = $urandom;
            dma.mem_r_ready = $urandom_range(0, 1) == 1;
            dma.mem_r_addr  = AW'($urandom_range(0, 63));
            cycle();
        end
        dma.mem_w_valid = 1'b0;
        dma.mem_r_ready = 1'b0;
        idle(10);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_inflight", 32'(last_inflight), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
